// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_pkg
// Purpose  : AXI4 burst/response encodings, read-side FSM state encoding and
//            the read-command legality check, shared by master and slave blocks.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [1:0] rd_state_t;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] R_DONE = 2'd3;

    // max_size is log2 of the data bus width in bytes
    function automatic logic cmd_is_illegal(
        input logic [1:0]  burst,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input int unsigned max_size
    );
        logic bad_wrap;
        logic bad_size;
        bad_wrap = (burst == BURST_WRAP) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        bad_size = (32'(size) > max_size);
        return (burst == BURST_RSVD) || bad_wrap || bad_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_master_read_channel_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_master_read_channel_if
// Purpose  : AXI4 AR + R channel bundle with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_master_read_channel_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rid, rresp, rlast,
        output rready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rid, rresp, rlast,
        input  rready
    );

endinterface
`default_nettype wire

// File: rtl/axi4_master_read_channel.sv
`default_nettype none
// ============================================================================
// Module   : axi4_master_read_channel
// Purpose  : Single-outstanding AXI4 read master: takes one command, issues AR,
//            forwards R beats as registered pulses and reports a done summary.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_master_read_channel
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,

    input  wire logic                  cmd_valid,
    output logic                       cmd_ready,
    input  wire logic [ADDR_WIDTH-1:0] cmd_addr,
    input  wire logic [ID_WIDTH-1:0]   cmd_id,
    input  wire logic [7:0]            cmd_len,
    input  wire logic [2:0]            cmd_size,
    input  wire logic [1:0]            cmd_burst,

    axi4_master_read_channel_if.master axi,

    input  wire logic                  out_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [7:0]                 out_beat,

    output logic                       done,
    output logic [1:0]                 done_resp,
    output logic                       cmd_err,
    output logic                       id_err,
    output logic                       last_err
);

    localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

    rd_state_t             state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [ID_WIDTH-1:0]   id_q,       id_d;
    logic [7:0]            len_q,      len_d;
    logic [2:0]            size_q,     size_d;
    logic [1:0]            burst_q,    burst_d;
    logic [8:0]            beat_q,     beat_d;
    logic [1:0]            resp_q,     resp_d;
    logic                  cmd_err_q,  cmd_err_d;
    logic                  id_err_q,   id_err_d;
    logic                  last_err_q, last_err_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]            out_beat_q, out_beat_d;

    logic cmd_accept;
    logic r_hs;
    logic final_beat;

    assign cmd_accept = cmd_valid && (state_q == R_IDLE);
    assign r_hs       = axi.rvalid && axi.rready;
    assign final_beat = (beat_q == {1'b0, len_q});

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        id_d        = id_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        resp_d      = resp_q;
        cmd_err_d   = cmd_err_q;
        id_err_d    = id_err_q;
        last_err_d  = last_err_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_beat_d  = out_beat_q;

        case (state_q)
            R_IDLE: begin
                if (cmd_accept) begin
                    addr_d     = cmd_addr;
                    id_d       = cmd_id;
                    len_d      = cmd_len;
                    size_d     = cmd_size;
                    burst_d    = cmd_burst;
                    beat_d     = 9'd0;
                    resp_d     = RESP_OKAY;
                    id_err_d   = 1'b0;
                    last_err_d = 1'b0;
                    if (cmd_is_illegal(cmd_burst, cmd_len, cmd_size, MAX_SIZE)) begin
                        cmd_err_d = 1'b1;
                        resp_d    = RESP_SLVERR;
                        state_d   = R_DONE;
                    end else begin
                        cmd_err_d = 1'b0;
                        state_d   = R_ADDR;
                    end
                end
            end

            R_ADDR: begin
                if (axi.arready) begin
                    state_d = R_DATA;
                end
            end

            R_DATA: begin
                if (r_hs) begin
                    out_valid_d = 1'b1;
                    out_data_d  = axi.rdata;
                    out_beat_d  = beat_q[7:0];
                    beat_d      = beat_q + 9'd1;
                    if (axi.rresp > resp_q) begin
                        resp_d = axi.rresp;
                    end
                    if (axi.rid != id_q) begin
                        id_err_d = 1'b1;
                    end
                    // Either an early rlast or a missing rlast on the last
                    // expected beat terminates the burst and flags it.
                    if (axi.rlast != final_beat) begin
                        last_err_d = 1'b1;
                    end
                    if (axi.rlast || final_beat) begin
                        state_d = R_DONE;
                    end
                end
            end

            R_DONE: begin
                state_d = R_IDLE;
            end

            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= R_IDLE;
            addr_q      <= '0;
            id_q        <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            resp_q      <= '0;
            cmd_err_q   <= 1'b0;
            id_err_q    <= 1'b0;
            last_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beat_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            resp_q      <= resp_d;
            cmd_err_q   <= cmd_err_d;
            id_err_q    <= id_err_d;
            last_err_q  <= last_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beat_q  <= out_beat_d;
        end
    end

    // cmd_ready is held low while reset is asserted, not just by the FSM state
    assign cmd_ready   = rst && (state_q == R_IDLE);

    assign axi.arvalid = (state_q == R_ADDR);
    assign axi.araddr  = addr_q;
    assign axi.arid    = id_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = size_q;
    assign axi.arburst = burst_q;
    assign axi.rready  = (state_q == R_DATA) && out_ready;

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_beat    = out_beat_q;

    assign done        = (state_q == R_DONE);
    assign done_resp   = resp_q;
    assign cmd_err     = cmd_err_q;
    assign id_err      = id_err_q;
    assign last_err    = last_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_master_read_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_master_read_channel
// Purpose  : Directed self-checking bench for axi4_master_read_channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_master_read_channel;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_id;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_beat;
    logic        done;
    logic [1:0]  done_resp;
    logic        cmd_err;
    logic        id_err;
    logic        last_err;

    int total = 0;
    int bad   = 0;

    axi4_master_read_channel_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

    axi4_master_read_channel #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_id    (cmd_id),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .axi       (axi),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_beat  (out_beat),
        .done      (done),
        .done_resp (done_resp),
        .cmd_err   (cmd_err),
        .id_err    (id_err),
        .last_err  (last_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        cmd_addr  = a;
        cmd_id    = id;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16 && cmd_ready !== 1'b1; i++) @(negedge clk);
        chk("cmd_ready_wait", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic ar_accept(input int delay, input logic [31:0] a, input logic [3:0] id,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        chk("ar_valid", axi.arvalid, 1);
        chk("ar_addr",  axi.araddr,  a);
        chk("ar_id",    axi.arid,    id);
        chk("ar_len",   axi.arlen,   len);
        chk("ar_size",  axi.arsize,  size);
        chk("ar_burst", axi.arburst, burst);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("ar_valid_hold", axi.arvalid, 1);
            chk("ar_addr_hold",  axi.araddr,  a);
            chk("ar_len_hold",   axi.arlen,   len);
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        chk("ar_valid_drop", axi.arvalid, 0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp,
                             input logic last, input logic [7:0] exp_beat);
        axi.rvalid = 1'b1;
        axi.rdata  = d;
        axi.rid    = id;
        axi.rresp  = resp;
        axi.rlast  = last;
        for (int i = 0; i < 16 && axi.rready !== 1'b1; i++) @(negedge clk);
        chk("rready_wait", axi.rready, 1);
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        chk("beat_valid", out_valid, 1);
        chk("beat_data",  out_data,  d);
        chk("beat_index", out_beat,  exp_beat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_id      = '0;
        cmd_len     = '0;
        cmd_size    = '0;
        cmd_burst   = '0;
        out_ready   = 1'b1;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rid     = '0;
        axi.rresp   = '0;
        axi.rlast   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready,   0);
        chk("rst_arvalid",   axi.arvalid, 0);
        chk("rst_rready",    axi.rready,  0);
        chk("rst_out_valid", out_valid,   0);
        chk("rst_done",      done,        0);
        rst = 1'b1;
        #1;
        chk("cmd_ready_up", cmd_ready, 1);

        // INCR len 3, AR delayed
        issue(32'h100, 4'd3, 8'd3, 3'd2, 2'b01);
        ar_accept(2, 32'h100, 4'd3, 8'd3, 3'd2, 2'b01);
        send_beat(32'hA0, 4'd3, 2'b00, 1'b0, 8'd0);
        @(negedge clk);
        chk("t1_single_pulse", out_valid, 0);
        send_beat(32'hA1, 4'd3, 2'b00, 1'b0, 8'd1);
        send_beat(32'hA2, 4'd3, 2'b00, 1'b0, 8'd2);
        send_beat(32'hA3, 4'd3, 2'b00, 1'b1, 8'd3);
        chk("t1_done",     done,      1);
        chk("t1_resp",     done_resp, 0);
        chk("t1_cmd_err",  cmd_err,   0);
        chk("t1_id_err",   id_err,    0);
        chk("t1_last_err", last_err,  0);
        @(negedge clk);
        chk("t1_done_drop", done,      0);
        chk("t1_idle",      cmd_ready, 1);

        // Backpressure for 5 cycles mid-burst
        issue(32'h200, 4'd1, 8'd3, 3'd2, 2'b01);
        ar_accept(0, 32'h200, 4'd1, 8'd3, 3'd2, 2'b01);
        send_beat(32'hB0, 4'd1, 2'b00, 1'b0, 8'd0);
        out_ready  = 1'b0;
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hB1;
        axi.rid    = 4'd1;
        axi.rresp  = 2'b00;
        axi.rlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rready",    axi.rready, 0);
            chk("bp_out_valid", out_valid,  0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rready_up", axi.rready, 1);
        @(negedge clk);
        axi.rvalid = 1'b0;
        chk("bp_valid", out_valid, 1);
        chk("bp_data",  out_data,  32'hB1);
        chk("bp_beat",  out_beat,  8'd1);
        send_beat(32'hB2, 4'd1, 2'b00, 1'b0, 8'd2);
        send_beat(32'hB3, 4'd1, 2'b00, 1'b1, 8'd3);
        chk("bp_done",     done,     1);
        chk("bp_last_err", last_err, 0);
        @(negedge clk);

        // Worst response
        issue(32'h300, 4'd2, 8'd2, 3'd2, 2'b01);
        ar_accept(0, 32'h300, 4'd2, 8'd2, 3'd2, 2'b01);
        send_beat(32'hC0, 4'd2, 2'b00, 1'b0, 8'd0);
        send_beat(32'hC1, 4'd2, 2'b11, 1'b0, 8'd1);
        send_beat(32'hC2, 4'd2, 2'b10, 1'b1, 8'd2);
        chk("resp_done",  done,      1);
        chk("resp_worst", done_resp, 2'b11);
        chk("resp_id_ok", id_err,    0);
        @(negedge clk);

        // Wrong rid still consumed
        issue(32'h340, 4'd2, 8'd0, 3'd2, 2'b01);
        ar_accept(0, 32'h340, 4'd2, 8'd0, 3'd2, 2'b01);
        send_beat(32'hC5, 4'd5, 2'b00, 1'b1, 8'd0);
        chk("id_done",     done,     1);
        chk("id_err",      id_err,   1);
        chk("id_last_err", last_err, 0);
        @(negedge clk);

        // Early rlast on beat 1 of len 3
        issue(32'h400, 4'd4, 8'd3, 3'd2, 2'b01);
        ar_accept(0, 32'h400, 4'd4, 8'd3, 3'd2, 2'b01);
        send_beat(32'hD0, 4'd4, 2'b00, 1'b0, 8'd0);
        chk("early_not_done", done, 0);
        send_beat(32'hD1, 4'd4, 2'b00, 1'b1, 8'd1);
        chk("early_done",     done,     1);
        chk("early_last_err", last_err, 1);
        @(negedge clk);
        chk("early_done_drop", done, 0);

        // Missing rlast on len 1
        issue(32'h500, 4'd4, 8'd1, 3'd2, 2'b01);
        ar_accept(0, 32'h500, 4'd4, 8'd1, 3'd2, 2'b01);
        send_beat(32'hD8, 4'd4, 2'b00, 1'b0, 8'd0);
        chk("nolast_not_done", done, 0);
        send_beat(32'hD9, 4'd4, 2'b00, 1'b0, 8'd1);
        chk("nolast_done",     done,     1);
        chk("nolast_last_err", last_err, 1);
        @(negedge clk);

        // Illegal: WRAP with len 2
        issue(32'h600, 4'd0, 8'd2, 3'd2, 2'b10);
        chk("wrap_arvalid", axi.arvalid, 0);
        chk("wrap_done",    done,        1);
        chk("wrap_cmd_err", cmd_err,     1);
        chk("wrap_resp",    done_resp,   2'b10);
        @(negedge clk);
        chk("wrap_arvalid2", axi.arvalid, 0);
        chk("wrap_done_drop", done,       0);

        // Illegal: size 3 on a 32-bit bus
        issue(32'h700, 4'd0, 8'd0, 3'd3, 2'b01);
        chk("size_arvalid", axi.arvalid, 0);
        chk("size_done",    done,        1);
        chk("size_cmd_err", cmd_err,     1);
        chk("size_resp",    done_resp,   2'b10);
        @(negedge clk);
        chk("size_arvalid2", axi.arvalid, 0);

        // Reset during beat 2 of len 7
        issue(32'h800, 4'd6, 8'd7, 3'd2, 2'b01);
        ar_accept(0, 32'h800, 4'd6, 8'd7, 3'd2, 2'b01);
        send_beat(32'hE0, 4'd6, 2'b00, 1'b0, 8'd0);
        send_beat(32'hE1, 4'd6, 2'b00, 1'b0, 8'd1);
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hE2;
        axi.rid    = 4'd6;
        rst        = 1'b0;
        #1;
        chk("mrst_arvalid",   axi.arvalid, 0);
        chk("mrst_rready",    axi.rready,  0);
        chk("mrst_out_valid", out_valid,   0);
        chk("mrst_cmd_ready", cmd_ready,   0);
        @(negedge clk);
        chk("mrst_done",      done,      0);
        chk("mrst_out_beat",  out_beat,  8'd0);
        chk("mrst_out_data",  out_data,  32'd0);
        rst        = 1'b1;
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("mrst_no_done", done, 0);

        issue(32'h900, 4'd6, 8'd0, 3'd2, 2'b01);
        ar_accept(0, 32'h900, 4'd6, 8'd0, 3'd2, 2'b01);
        send_beat(32'hF0, 4'd6, 2'b00, 1'b1, 8'd0);
        chk("post_done",     done,      1);
        chk("post_resp",     done_resp, 0);
        chk("post_cmd_err",  cmd_err,   0);
        chk("post_id_err",   id_err,    0);
        chk("post_last_err", last_err,  0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_master_read_channel.md
AXI4_MASTER_READ_CHANNEL -- requirements
Module: axi4_master_read_channel

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning R data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address width in bits.
REQ-003 SHALL have parameter ID_WIDTH, default 4, meaning AXI ID width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a read command is offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: a read command is accepted.
REQ-008 SHALL have cmd_addr/cmd_id/cmd_len/cmd_size/cmd_burst, inputs, ADDR_WIDTH/ID_WIDTH/8/3/2 bits: command fields.
REQ-009 SHALL have arvalid, output, 1 bit, and arready, input, 1 bit: AR handshake.
REQ-010 SHALL have araddr/arid/arlen/arsize/arburst, outputs, ADDR_WIDTH/ID_WIDTH/8/3/2 bits: AR payload.
REQ-011 SHALL have rvalid, input, 1 bit, and rready, output, 1 bit: R handshake.
REQ-012 SHALL have rdata/rid/rresp/rlast, inputs, DATA_WIDTH/ID_WIDTH/2/1 bits: R payload.
REQ-013 SHALL have out_ready, input, 1 bit: the consumer can take a beat.
REQ-014 SHALL have out_valid/out_data/out_beat, outputs, 1/DATA_WIDTH/8 bits: registered beat, data and beat index.
REQ-015 SHALL have done/done_resp, outputs, 1/2 bits: completion pulse and worst response.
REQ-016 SHALL have cmd_err/id_err/last_err, outputs, 1 bit each: error flags, valid while done=1.

Function
REQ-017 SHALL implement FSM states R_IDLE, R_ADDR, R_DATA and R_DONE.
REQ-018 In R_IDLE, SHALL drive cmd_ready=1; on cmd_valid, SHALL latch all command fields and go to R_ADDR, or to R_DONE with cmd_err=1 if the command is illegal.
REQ-019 A command is illegal if burst=2'b11, if WRAP has cmd_len not in {1,3,7,15}, or if 2^cmd_size > DATA_WIDTH/8; an illegal command SHALL issue no AR.
REQ-020 In R_ADDR, SHALL drive arvalid=1 with the AR payload equal to the latched fields, held stable until arready; arvalid first rises the cycle after command acceptance.
REQ-021 On the AR handshake, SHALL drop arvalid the next cycle and enter R_DATA.
REQ-022 In R_DATA, SHALL drive rready=out_ready combinationally; outside R_DATA, rready SHALL be 0.
REQ-023 For each R handshake, SHALL register rdata into out_data, the beat count (0-based) into out_beat, and pulse out_valid=1 for exactly one cycle on the following cycle.
REQ-024 SHALL track the worst response as the numeric max of rresp over beats (OKAY < EXOKAY < SLVERR < DECERR).
REQ-025 SHALL set the sticky id_err if rid differs from the latched ID on any beat, and SHALL still consume that beat.
REQ-026 SHALL expect beat cmd_len to be the final beat.
REQ-027 If rlast=1 arrives earlier than the final beat, SHALL set last_err and end the burst on that beat.
REQ-028 If the final beat arrives with rlast=0, SHALL set last_err and still end the burst.
REQ-029 At the end of the burst, SHALL go to R_DONE the next cycle.
REQ-030 In R_DONE, SHALL assert done=1 for one cycle with done_resp and the error flags valid, then return to R_IDLE; errors SHALL clear on the next command acceptance.
REQ-031 For a command error, done_resp SHALL be SLVERR (2'b10).
REQ-032 The beat counter SHALL be 9 bits so that cmd_len=255 (256 beats) does not wrap.
REQ-033 cmd_ready SHALL be 0 in every state except R_IDLE, so only one burst is outstanding.

Reset
REQ-034 When rst=0, SHALL go to R_IDLE and clear every output and register to 0, except cmd_ready, which SHALL be 1 once rst=1.
REQ-035 A reset mid-burst SHALL drop arvalid/rready immediately, produce no done pulse, and discard the partial burst.

Structure
REQ-036 Package axi4_pkg SHALL hold the burst encodings (FIXED/INCR/WRAP), the RESP constants and the FSM state typedef, shared with the slave-side blocks.
REQ-037 SHALL be a single module with no sub-module; the beat counter and error logic SHALL be inline.

Verification
REQ-038 SHALL test INCR: addr 0x100, len 3, size 2, arready delayed 2 cycles -> AR payload stable, 4 out_valid pulses with out_beat 0..3, done with done_resp=00 and no errors.
REQ-039 SHALL test backpressure: out_ready low for 5 cycles mid-burst -> rready=0 during those cycles and no beat lost or duplicated.
REQ-040 SHALL test responses: len 2 with rresp 00,11,10 -> done_resp=11.
REQ-041 SHALL test rlast: rlast on beat 1 of len 3 -> last_err=1 and done after 2 beats; len 1 with rlast never set -> last_err=1 after 2 beats.
REQ-042 SHALL test illegal commands: WRAP len 2, or size 3 with DATA_WIDTH 32 -> arvalid never rises, done with cmd_err=1 and done_resp=10.
REQ-043 SHALL test reset mid-burst: rst low during beat 2 of len 7 -> outputs 0 next cycle, and the next command completes normally.
